// File: rtl/bcd_score_tracker_if.sv
// Control pulses and status outputs of the BCD score tracker.
// master drives the game events; slave is the tracker itself.
interface bcd_score_tracker_if #(
    parameter int DIGITS = 4
);
    logic                  game_start;
    logic                  game_over;
    logic                  game_tick;
    logic                  pause;
    logic                  bonus;
    logic [3:0]            bonus_amt;
    logic [4*DIGITS-1:0]   score;
    logic [4*DIGITS-1:0]   high_score;
    logic                  active;
    logic                  paused;
    logic                  overflow;
    logic                  new_high;

    modport master (
        output game_start, game_over, game_tick, pause, bonus, bonus_amt,
        input  score, high_score, active, paused, overflow, new_high
    );

    modport slave (
        input  game_start, game_over, game_tick, pause, bonus, bonus_amt,
        output score, high_score, active, paused, overflow, new_high
    );
endinterface

// File: rtl/bcd_score_tracker.sv
// Game score keeper: packed-BCD score with single-cycle decimal carry ripple,
// saturating or wrapping on overflow, and a high score latched at game end.
module bcd_score_tracker #(
    parameter int DIGITS = 4,
    parameter bit WRAP   = 1'b0
) (
    input logic                clk,
    input logic                rst_n,
    bcd_score_tracker_if.slave bus
);
    localparam int W = 4 * DIGITS;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, OVER} state_t;

    state_t         state, next_state;
    logic [W-1:0]   score_q, score_d;
    logic [W-1:0]   high_q, high_d;
    logic           overflow_q, overflow_d;
    logic           new_high_q, new_high_d;
    logic           active_q, paused_q;

    logic           in_game;
    logic           start_evt, over_evt, pause_evt, score_evt;
    logic [3:0]     bonus_clip, incr;
    logic [4:0]     digit_sum, digit_adj;
    logic           carry;
    logic [W-1:0]   sum_bcd, add_result;

    // One accepted event per cycle: game_start > game_over > pause > scoring.
    always_comb begin
        in_game   = (state == RUN) || (state == PAUSE);
        start_evt = bus.game_start;
        over_evt  = !start_evt && bus.game_over && in_game;
        pause_evt = !start_evt && !over_evt && bus.pause && in_game;
        score_evt = !start_evt && !over_evt && !pause_evt && (state == RUN);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (start_evt)      next_state = RUN;
        else if (over_evt)  next_state = OVER;
        else if (pause_evt) next_state = (state == RUN) ? PAUSE : RUN;
    end

    // Decimal add of 0..10 into the score, carry rippling through every digit.
    always_comb begin
        bonus_clip = (bus.bonus_amt > 4'd9) ? 4'd9 : bus.bonus_amt;
        incr       = (bus.bonus ? bonus_clip : 4'd0) + {3'b000, bus.game_tick};
        carry      = 1'b0;
        sum_bcd    = '0;
        digit_sum  = '0;
        digit_adj  = '0;
        for (int i = 0; i < DIGITS; i++) begin
            digit_sum = {1'b0, score_q[4*i +: 4]} +
                        ((i == 0) ? {1'b0, incr} : {4'b0000, carry});
            digit_adj = digit_sum - 5'd10;
            if (digit_sum >= 5'd10) begin
                sum_bcd[4*i +: 4] = digit_adj[3:0];
                carry             = 1'b1;
            end else begin
                sum_bcd[4*i +: 4] = digit_sum[3:0];
                carry             = 1'b0;
            end
        end
        add_result = carry ? (WRAP ? sum_bcd : {DIGITS{4'h9}}) : sum_bcd;
    end

    // NOTE: every output of this block is given a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        score_d    = score_q;
        high_d     = high_q;
        overflow_d = overflow_q;
        new_high_d = 1'b0;
        if (start_evt) begin
            score_d    = '0;
            overflow_d = 1'b0;
        end else if (over_evt) begin
            // Packed BCD orders like its binary image, so a plain compare works.
            if (score_q > high_q) begin
                high_d     = score_q;
                new_high_d = 1'b1;
            end
        end else if (score_evt) begin
            score_d = add_result;
            if (carry) overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score_q    <= '0;
            high_q     <= '0;
            overflow_q <= 1'b0;
            new_high_q <= 1'b0;
            active_q   <= 1'b0;
            paused_q   <= 1'b0;
        end else begin
            score_q    <= score_d;
            high_q     <= high_d;
            overflow_q <= overflow_d;
            new_high_q <= new_high_d;
            active_q   <= (next_state == RUN) || (next_state == PAUSE);
            paused_q   <= (next_state == PAUSE);
        end
    end

    assign bus.score      = score_q;
    assign bus.high_score = high_q;
    assign bus.overflow   = overflow_q;
    assign bus.new_high   = new_high_q;
    assign bus.active     = active_q;
    assign bus.paused     = paused_q;
endmodule

// File: tb/tb_bcd_score_tracker.sv
// Scoreboard bench: a saturating and a wrapping tracker share stimulus and are
// compared each cycle against an integer-arithmetic model of the game rules.
module tb_bcd_score_tracker;
    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;
    localparam int MAXV   = 9999;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bcd_score_tracker_if #(.DIGITS(DIGITS)) bus_s ();
    bcd_score_tracker_if #(.DIGITS(DIGITS)) bus_w ();

    bcd_score_tracker #(.DIGITS(DIGITS), .WRAP(1'b0)) dut_s (
        .clk(clk), .rst_n(rst_n), .bus(bus_s)
    );
    bcd_score_tracker #(.DIGITS(DIGITS), .WRAP(1'b1)) dut_w (
        .clk(clk), .rst_n(rst_n), .bus(bus_w)
    );

    typedef struct packed {
        logic [W-1:0] score;
        logic [W-1:0] high;
        logic         active;
        logic         paused;
        logic         ovf;
        logic         nh;
    } exp_t;

    typedef enum {M_IDLE, M_RUN, M_PAUSE, M_OVER} mstate_e;

    int      total = 0;
    int      bad   = 0;
    exp_t    q_s[$];
    exp_t    q_w[$];

    mstate_e m_st;
    int      m_score[2];
    int      m_high[2];
    bit      m_ovf[2];
    bit      m_nh[2];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic void model_reset();
        m_st = M_IDLE;
        for (int k = 0; k < 2; k++) begin
            m_score[k] = 0; m_high[k] = 0; m_ovf[k] = 0; m_nh[k] = 0;
        end
    endfunction

    // k = 0 saturates at 9999, k = 1 wraps modulo 10000.
    function automatic void model_step(input bit start, input bit over, input bit tick,
                                       input bit pse, input bit bon, input logic [3:0] amt);
        bit ingame;
        int inc, s;
        ingame = (m_st == M_RUN) || (m_st == M_PAUSE);
        inc    = (tick ? 1 : 0) + (bon ? ((amt > 9) ? 9 : int'(amt)) : 0);
        for (int k = 0; k < 2; k++) m_nh[k] = 0;
        if (start) begin
            m_st = M_RUN;
            for (int k = 0; k < 2; k++) begin m_score[k] = 0; m_ovf[k] = 0; end
        end else if (over && ingame) begin
            m_st = M_OVER;
            for (int k = 0; k < 2; k++)
                if (m_score[k] > m_high[k]) begin m_high[k] = m_score[k]; m_nh[k] = 1; end
        end else if (pse && ingame) begin
            m_st = (m_st == M_RUN) ? M_PAUSE : M_RUN;
        end else if (m_st == M_RUN) begin
            for (int k = 0; k < 2; k++) begin
                s = m_score[k] + inc;
                if (s > MAXV) begin
                    m_ovf[k]   = 1;
                    m_score[k] = (k == 1) ? s % (MAXV + 1) : MAXV;
                end else begin
                    m_score[k] = s;
                end
            end
        end
    endfunction

    function automatic exp_t model_out(input int k);
        exp_t e;
        e.score  = to_bcd(m_score[k]);
        e.high   = to_bcd(m_high[k]);
        e.active = (m_st == M_RUN) || (m_st == M_PAUSE);
        e.paused = (m_st == M_PAUSE);
        e.ovf    = m_ovf[k];
        e.nh     = m_nh[k];
        return e;
    endfunction

    task automatic drive(input bit start, input bit over, input bit tick,
                         input bit pse, input bit bon, input logic [3:0] amt);
        bus_s.game_start = start; bus_w.game_start = start;
        bus_s.game_over  = over;  bus_w.game_over  = over;
        bus_s.game_tick  = tick;  bus_w.game_tick  = tick;
        bus_s.pause      = pse;   bus_w.pause      = pse;
        bus_s.bonus      = bon;   bus_w.bonus      = bon;
        bus_s.bonus_amt  = amt;   bus_w.bonus_amt  = amt;
    endtask

    // One cycle of stimulus; expectation for the following rising edge is queued.
    task automatic step(input bit start, input bit over, input bit tick,
                        input bit pse, input bit bon, input logic [3:0] amt);
        @(negedge clk);
        drive(start, over, tick, pse, bon, amt);
        if (rst_n) model_step(start, over, tick, pse, bon, amt);
        else       model_reset();
        q_s.push_back(model_out(0));
        q_w.push_back(model_out(1));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 4'd0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 1, 0, 0, 4'd0);
    endtask

    task automatic observe();
        @(posedge clk);
        #1;
    endtask

    task automatic compare(input string tag, input exp_t e, input exp_t g);
        check({tag, " score"},    32'(g.score),  32'(e.score));
        check({tag, " high"},     32'(g.high),   32'(e.high));
        check({tag, " active"},   32'(g.active), 32'(e.active));
        check({tag, " paused"},   32'(g.paused), 32'(e.paused));
        check({tag, " overflow"}, 32'(g.ovf),    32'(e.ovf));
        check({tag, " new_high"}, 32'(g.nh),     32'(e.nh));
    endtask

    // Monitor: pops one expectation per DUT per rising edge that has one queued.
    initial begin
        exp_t e, g;
        forever begin
            @(posedge clk);
            #1;
            if (q_s.size() > 0) begin
                e = q_s.pop_front();
                g = '{bus_s.score, bus_s.high_score, bus_s.active, bus_s.paused,
                      bus_s.overflow, bus_s.new_high};
                compare("sat", e, g);
            end
            if (q_w.size() > 0) begin
                e = q_w.pop_front();
                g = '{bus_w.score, bus_w.high_score, bus_w.active, bus_w.paused,
                      bus_w.overflow, bus_w.new_high};
                compare("wrap", e, g);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, " score"},    32'(bus_s.score),      0);
        check({tag, " high"},     32'(bus_s.high_score), 0);
        check({tag, " active"},   32'(bus_s.active),     0);
        check({tag, " paused"},   32'(bus_s.paused),     0);
        check({tag, " overflow"}, 32'(bus_s.overflow),   0);
        check({tag, " new_high"}, 32'(bus_s.new_high),   0);
        check({tag, " wrap score"}, 32'(bus_w.score),    0);
        check({tag, " wrap high"},  32'(bus_w.high_score), 0);
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 4'd0);
        model_reset();
        // Pulses during reset must be ignored.
        step(1, 0, 1, 0, 1, 4'd5);
        idle(2);
        check_all_zero("reset");
        rst_n = 1'b1;

        // Start, 1234 ticks, game over.
        step(1, 0, 0, 0, 0, 4'd0);
        ticks(1234);
        step(0, 1, 0, 0, 0, 4'd0);
        observe();
        check("g1 score",    32'(bus_s.score),      32'h1234);
        check("g1 high",     32'(bus_s.high_score), 32'h1234);
        check("g1 new_high", 32'(bus_s.new_high),   1);
        check("g1 active",   32'(bus_s.active),     0);
        step(0, 0, 1, 1, 1, 4'd3);
        observe();
        check("g1 new_high drop", 32'(bus_s.new_high), 0);
        check("g1 score frozen",  32'(bus_s.score),    32'h1234);

        // Ripple through two digits in one cycle; clipped bonus amount.
        step(1, 0, 0, 0, 0, 4'd0);
        ticks(99);
        step(0, 0, 1, 0, 1, 4'd9);
        observe();
        check("ripple 0109", 32'(bus_s.score), 32'h0109);
        step(0, 0, 0, 0, 1, 4'hF);
        observe();
        check("bonus clip", 32'(bus_s.score), 32'h0118);

        // Pause gap swallows ticks.
        step(1, 0, 0, 0, 0, 4'd0);
        step(0, 0, 0, 1, 0, 4'd0);
        observe();
        check("paused set", 32'(bus_s.paused), 1);
        ticks(50);
        step(0, 0, 0, 1, 0, 4'd0);
        observe();
        check("paused clr", 32'(bus_s.paused), 0);
        ticks(3);
        observe();
        check("pause score", 32'(bus_s.score), 32'h0003);

        // Lower second game keeps the old high score.
        ticks(997);
        step(0, 1, 0, 0, 0, 4'd0);
        observe();
        check("g2 score",    32'(bus_s.score),      32'h1000);
        check("g2 high",     32'(bus_s.high_score), 32'h1234);
        check("g2 new_high", 32'(bus_s.new_high),   0);

        // game_start beats game_over in the same cycle.
        step(1, 0, 0, 0, 0, 4'd0);
        ticks(5);
        step(1, 1, 1, 1, 1, 4'd9);
        observe();
        check("start>over active", 32'(bus_s.active), 1);
        check("start>over paused", 32'(bus_s.paused), 0);
        check("start>over score",  32'(bus_s.score),  0);

        // Overflow: saturate vs wrap.
        step(1, 0, 0, 0, 0, 4'd0);
        for (int i = 0; i < 1110; i++) step(0, 0, 0, 0, 1, 4'd9);
        ticks(5);
        observe();
        check("pre-ovf score", 32'(bus_s.score), 32'h9995);
        step(0, 0, 0, 0, 1, 4'd7);
        observe();
        check("sat score",  32'(bus_s.score),    32'h9999);
        check("sat ovf",    32'(bus_s.overflow), 1);
        check("wrap score", 32'(bus_w.score),    32'h0002);
        check("wrap ovf",   32'(bus_w.overflow), 1);
        step(0, 0, 1, 0, 0, 4'd0);
        observe();
        check("sat hold",    32'(bus_s.score),    32'h9999);
        check("sat ovf2",    32'(bus_s.overflow), 1);
        check("wrap tick",   32'(bus_w.score),    32'h0003);
        step(0, 1, 0, 0, 0, 4'd0);
        observe();
        check("sat high 9999", 32'(bus_s.high_score), 32'h9999);
        check("wrap high kept", 32'(bus_w.high_score), 32'h1234);

        // Equal score must not update (wrapping unit holds 1234).
        step(1, 0, 0, 0, 0, 4'd0);
        observe();
        check("restart ovf clr", 32'(bus_s.overflow), 0);
        ticks(1234);
        step(0, 1, 0, 0, 0, 4'd0);
        observe();
        check("equal no new_high", 32'(bus_w.new_high), 0);
        check("equal high",        32'(bus_w.high_score), 32'h1234);

        // Asynchronous reset mid-game at 0500.
        step(1, 0, 0, 0, 0, 4'd0);
        ticks(500);
        observe();
        check("pre-reset score", 32'(bus_s.score), 32'h0500);
        @(negedge clk);
        drive(0, 0, 1, 0, 0, 4'd0);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("async reset");
        model_reset();
        q_s.push_back(model_out(0));
        q_w.push_back(model_out(1));
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 4'd0);
        rst_n = 1'b1;
        // IDLE: a tick alone must do nothing, then start is honoured.
        step(0, 0, 1, 0, 0, 4'd0);
        step(1, 0, 0, 0, 0, 4'd0);
        observe();
        check("post-reset active", 32'(bus_s.active), 1);

        // Randomized play.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(99) < 1, $urandom_range(99) < 1, $urandom_range(1) == 1,
                 $urandom_range(99) < 3, $urandom_range(99) < 30, 4'($urandom_range(15)));
        end

        idle(3);
        observe();
        observe();
        check("queue s drained", 32'(q_s.size()), 0);
        check("queue w drained", 32'(q_w.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bcd_score_tracker.md
BCD_SCORE_TRACKER -- requirements
Module: bcd_score_tracker

Interface
REQ-001 Parameter DIGITS, default 4, number of BCD digits in score and high score (legal 1..8).
REQ-002 Parameter WRAP, default 0, 0 = saturate at all-9s, 1 = wrap modulo 10^DIGITS.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 game_start  input  1  one-cycle pulse; clear score and begin a game.
REQ-006 game_over  input  1  one-cycle pulse; end the current game.
REQ-007 game_tick  input  1  one-cycle end-of-frame pulse (60 Hz); +1 point while running.
REQ-008 pause  input  1  one-cycle pulse; toggles RUN and PAUSE.
REQ-009 bonus  input  1  one-cycle pulse; add bonus_amt points while running.
REQ-010 bonus_amt  input  4  BCD bonus value 0..9; values 10..15 treated as 9.
REQ-011 score  output  4*DIGITS  current score, packed BCD, digit 0 in bits [3:0].
REQ-012 high_score  output  4*DIGITS  best completed-game score, packed BCD.
REQ-013 active  output  1  high in RUN or PAUSE.
REQ-014 paused  output  1  high in PAUSE only.
REQ-015 overflow  output  1  sticky; set when any addition exceeds 10^DIGITS-1 in the current game.
REQ-016 new_high  output  1  one-cycle pulse when high_score is updated.

Function
REQ-017 State machine SHALL have states IDLE, RUN, PAUSE, OVER; all outputs registered.
REQ-018 IDLE/OVER + game_start -> RUN; score, overflow cleared on same edge.
REQ-019 RUN/PAUSE + game_start -> RUN (restart); score, overflow cleared; high_score untouched.
REQ-020 RUN + pause -> PAUSE; PAUSE + pause -> RUN; pause ignored in IDLE/OVER.
REQ-021 RUN/PAUSE + game_over -> OVER; score held; game_over ignored in IDLE/OVER.
REQ-022 Priority when pulses coincide: game_start > game_over > pause > scoring.
REQ-023 Scoring only in RUN and only on cycles with no higher-priority pulse; increment = (game_tick ? 1 : 0) + (bonus ? bonus_amt : 0), range 0..10, applied in one cycle.
REQ-024 Addition SHALL be decimal with carry ripple across all DIGITS within the same cycle; each digit always 0..9.
REQ-025 Latency: score reflects a scoring pulse on the next rising edge after it is sampled.
REQ-026 Sum > 10^DIGITS-1: WRAP=0 -> score = all 9s; WRAP=1 -> score = sum mod 10^DIGITS; both set overflow.
REQ-027 At all-9s with WRAP=0 further increments leave score unchanged; overflow stays 1.
REQ-028 On RUN/PAUSE -> OVER edge, if score > high_score (unsigned BCD compare), high_score <= score and new_high = 1 for exactly one cycle; equal score SHALL NOT update.
REQ-029 Restart via REQ-019 SHALL NOT update high_score or pulse new_high.
REQ-030 Scoring pulses in PAUSE, IDLE, OVER SHALL be ignored without effect.

Reset
REQ-031 rst_n low SHALL immediately force state IDLE, score 0, high_score 0, overflow 0, new_high 0, active 0, paused 0.
REQ-032 Reset mid-game SHALL discard score and high_score; no new_high pulse.
REQ-033 After rst_n deasserts, inputs are honoured from the first rising edge.

Verification (DIGITS=4 unless stated)
REQ-034 Start, 1234 ticks, game_over -> score 0x1234, high_score 0x1234, new_high one cycle, active 0.
REQ-035 Score 0x0099, tick + bonus (amt 9) same cycle -> score 0x0109 next edge.
REQ-036 WRAP=0, score 0x9995, bonus amt 7 -> score 0x9999, overflow 1; further tick -> 0x9999; WRAP=1 same stimulus -> 0x0002, overflow 1.
REQ-037 RUN, pause, 50 ticks, pause, 3 ticks -> score 0x0003, paused 1 only during gap.
REQ-038 Second game ending at 0x1000 after high 0x1234 -> high_score 0x1234, no new_high; game_start + game_over same cycle in RUN -> RUN, score 0.
REQ-039 rst_n asserted mid-game at score 0x0500 -> all outputs 0 asynchronously, state IDLE.
